// File: rtl/io_input_handshake.sv
// IN-instruction front end: synchronizes switches and Enter, debounces Enter,
// and holds the core in stall until a fresh press latches the switch word.
module io_input_handshake #(
    parameter int DATA_W          = 17,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              In,
    input  logic [DATA_W-1:0] switches,
    input  logic              enter_btn,
    output logic [DATA_W-1:0] inputFPGA,
    output logic              stall,
    output logic              in_valid
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync;
    logic [SYNC_STAGES-1:0]             en_sync;
    logic [DATA_W-1:0]                  sw_s;
    logic                               en_s;
    logic                               enter_db;
    logic                               enter_db_q;
    logic [CNT_W-1:0]                   db_cnt;
    logic                               press;
    state_t                             state;

    assign sw_s  = sw_sync[SYNC_STAGES-1];
    assign en_s  = en_sync[SYNC_STAGES-1];
    assign press = enter_db & ~enter_db_q;

    // Index 0 takes the raw pin; the highest index is the synchronized copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_sync <= '0;
            en_sync <= '0;
        end else begin
            sw_sync <= {sw_sync[SYNC_STAGES-2:0], switches};
            en_sync <= {en_sync[SYNC_STAGES-2:0], enter_btn};
        end
    end

    // enter_db only moves after en_s has disagreed with it for a full window.
    always_ff @(posedge clock) begin
        if (reset) begin
            enter_db   <= 1'b0;
            enter_db_q <= 1'b0;
            db_cnt     <= '0;
        end else begin
            enter_db_q <= enter_db;
            if (en_s == enter_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                enter_db <= en_s;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            inputFPGA <= '0;
        end else begin
            case (state)
                IDLE:    if (In) state <= ARMED;
                ARMED: begin
                    if (!In) begin
                        state <= IDLE;
                    end else if (press) begin
                        inputFPGA <= sw_s;
                        state     <= GRANT;
                    end
                end
                GRANT:   state <= RELEASE;
                // Waiting for Enter to drop forces every IN to see its own press.
                RELEASE: if (!enter_db) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall    = (state == ARMED) | ((state == RELEASE) & In);
    assign in_valid = (state == GRANT);

endmodule

// File: tb/tb_io_input_handshake.sv
// Bench for io_input_handshake: directed scenarios plus a random run, every cycle
// compared against a window-based behavioural model of sync, debounce and handshake.
module tb_io_input_handshake;

    localparam int DW   = 17;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HL   = SYNC + DEB;

    localparam int P_IDLE = 0, P_WAIT = 1, P_GRANT = 2, P_DONE = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          In = 1'b0;
    logic [DW-1:0] switches = '0;
    logic          enter_btn = 1'b0;
    logic [DW-1:0] inputFPGA;
    logic          stall;
    logic          in_valid;

    io_input_handshake #(
        .DATA_W(DW), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock), .reset(reset), .In(In), .switches(switches),
        .enter_btn(enter_btn), .inputFPGA(inputFPGA), .stall(stall),
        .in_valid(in_valid)
    );

    always #5 clock = ~clock;

    int nasrt = 0;
    int nfail = 0;
    int nvalid = 0;

    // Model: raw input history (index 0 = sampled at the previous edge),
    // debounced level, its one-cycle-old copy, handshake phase and latched word.
    int            en_h [HL];
    logic [DW-1:0] sw_h [HL];
    int            m_db, m_dbq, m_ph;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit mpress();
        return (m_db == 1) && (m_dbq == 0);
    endfunction

    task automatic model_edge(input bit rst, input bit cin, input bit cen, input logic [DW-1:0] csw);
        int en_s;
        logic [DW-1:0] sw_s;
        bit same;
        if (rst) begin
            for (int k = 0; k < HL; k++) begin
                en_h[k] = 0;
                sw_h[k] = '0;
            end
            m_db = 0; m_dbq = 0; m_ph = P_IDLE; m_data = '0;
            return;
        end
        en_s = en_h[SYNC-1];
        sw_s = sw_h[SYNC-1];
        case (m_ph)
            P_IDLE:  if (cin) m_ph = P_WAIT;
            P_WAIT:  if (!cin) m_ph = P_IDLE;
                     else if (mpress()) begin m_data = sw_s; m_ph = P_GRANT; end
            P_GRANT: m_ph = P_DONE;
            default: if (m_db == 0) m_ph = P_IDLE;
        endcase
        // Debounced level flips once the last DEB synchronized samples all agree on the other value.
        same = 1'b1;
        for (int k = 0; k < DEB; k++)
            if (en_h[SYNC-1+k] != en_s) same = 1'b0;
        m_dbq = m_db;
        if (same && en_s != m_db) m_db = en_s;
        for (int k = HL-1; k > 0; k--) begin
            en_h[k] = en_h[k-1];
            sw_h[k] = sw_h[k-1];
        end
        en_h[0] = int'(cen);
        sw_h[0] = csw;
    endtask

    task automatic step();
        bit rst, cin, cen;
        logic [DW-1:0] csw;
        rst = reset; cin = In; cen = enter_btn; csw = switches;
        @(posedge clock);
        model_edge(rst, cin, cen, csw);
        #1;
        chk("stall", stall, (m_ph == P_WAIT) || (m_ph == P_DONE && In));
        chk("in_valid", in_valid, m_ph == P_GRANT);
        chk("inputFPGA", inputFPGA, m_data);
        if (in_valid === 1'b1) nvalid++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step();
            if (in_valid === 1'b1) seen = 1'b1;
        end
        chk(tag, seen, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0, lv, len, i, guard;
        logic [DW-1:0] held;

        // 1: reset, arm, then reset mid-ARMED
        run(3);
        reset = 1'b0;
        In = 1'b1; switches = 17'h1ABCD;
        run(3);
        chk("t1_armed_stall", stall, 1'b1);
        reset = 1'b1;
        step();
        chk("t1_rst_stall", stall, 1'b0);
        chk("t1_rst_data", inputFPGA, 17'h0);
        chk("t1_rst_valid", in_valid, 1'b0);
        reset = 1'b0; In = 1'b0;
        run(2);

        // 2: clean press captures 0F0F5
        In = 1'b1; switches = 17'h0F0F5;
        run(2);
        nv0 = nvalid;
        enter_btn = 1'b1;
        wait_valid("t2_grant", 12);
        chk("t2_stall_at_grant", stall, 1'b0);
        chk("t2_data", inputFPGA, 17'h0F0F5);
        In = 1'b0;
        run(3);
        enter_btn = 1'b0;
        run(10);
        chk("t2_one_pulse", nvalid - nv0, 1);

        // 3: bouncing Enter must not capture early
        In = 1'b1; switches = 17'h12345;
        run(2);
        nv0 = nvalid; lv = 0; i = 0;
        while (i < 20) begin
            lv = 1 - lv;
            enter_btn = lv[0];
            len = int'($urandom_range(1, 2));
            run(len);
            i += len;
        end
        chk("t3_no_early", nvalid - nv0, 0);
        chk("t3_still_stalled", stall, 1'b1);
        enter_btn = 1'b1;
        wait_valid("t3_grant", 12);
        chk("t3_data", inputFPGA, 17'h12345);
        In = 1'b0;
        run(3);
        enter_btn = 1'b0;
        run(10);
        chk("t3_one_pulse", nvalid - nv0, 1);

        // 4: Enter held before IN rises needs release and re-press
        enter_btn = 1'b1;
        run(10);
        nv0 = nvalid;
        In = 1'b1; switches = 17'h0AAAA;
        run(8);
        chk("t4_held_stall", stall, 1'b1);
        enter_btn = 1'b0;
        run(8);
        chk("t4_released_stall", stall, 1'b1);
        chk("t4_no_capture", nvalid - nv0, 0);
        enter_btn = 1'b1;
        wait_valid("t4_grant", 12);
        chk("t4_data", inputFPGA, 17'h0AAAA);
        In = 1'b0;
        run(2);
        enter_btn = 1'b0;
        run(10);

        // 5: back-to-back IN with Enter still held
        In = 1'b1; switches = 17'h00001;
        run(2);
        enter_btn = 1'b1;
        wait_valid("t5_grant1", 12);
        chk("t5_data1", inputFPGA, 17'h00001);
        switches = 17'h1FFFF;
        step();
        chk("t5_release_stall", stall, 1'b1);
        run(4);
        chk("t5_held_stall", stall, 1'b1);
        nv0 = nvalid;
        enter_btn = 1'b0;
        run(10);
        chk("t5_no_second", nvalid - nv0, 0);
        chk("t5_rearmed_stall", stall, 1'b1);
        enter_btn = 1'b1;
        wait_valid("t5_grant2", 12);
        chk("t5_data2", inputFPGA, 17'h1FFFF);
        In = 1'b0;
        run(2);
        enter_btn = 1'b0;
        run(10);

        // 6: IN drops on the very cycle a press arrives
        held = inputFPGA;
        In = 1'b1; switches = 17'h15555;
        run(2);
        nv0 = nvalid;
        enter_btn = 1'b1;
        guard = 0;
        while (!mpress() && guard < 12) begin
            step();
            guard++;
        end
        chk("t6_press_seen", mpress(), 1'b1);
        In = 1'b0;
        step();
        chk("t6_valid", in_valid, 1'b0);
        chk("t6_stall", stall, 1'b0);
        chk("t6_data_held", inputFPGA, 17'h1FFFF);
        run(3);
        chk("t6_no_pulse", nvalid - nv0, 0);
        chk("t6_data_still", inputFPGA, held);
        enter_btn = 1'b0;
        run(8);

        // Random traffic: sticky In/Enter levels, fresh switches, rare resets
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) In = ~In;
            if ($urandom_range(0, 5) == 0) enter_btn = ~enter_btn;
            switches = DW'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
